mem_wr_a: RTL and testbench
===========================

MEM_WR_A -- requirements
Module: mem_wr_a

Interface
REQ-001 SHALL have parameter MAX_ROW, default 540, frame height in pixels.
REQ-002 SHALL have parameter MAX_COL, default 540, frame width in pixels; frame size N = MAX_ROW*MAX_COL, N <= 2^19.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle request to begin writing one frame.
REQ-006 SHALL have port pix_valid_i  input  1  source has a pixel on pix_data_i.
REQ-007 SHALL have port pix_data_i  input  8  pixel value.
REQ-008 SHALL have port pix_ready_o  output  1  block accepts a pixel this cycle.
REQ-009 SHALL have port ena_o  output  1  BRAM port-A enable.
REQ-010 SHALL have port wea_o  output  1  BRAM port-A write enable.
REQ-011 SHALL have port addra_o  output  19  BRAM port-A address.
REQ-012 SHALL have port d2mema_o  output  8  BRAM port-A write data.
REQ-013 SHALL have port mem2da_i  input  8  BRAM port-A read data, unused and ignored.
REQ-014 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port frame_done_o  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-017 IDLE: pix_ready_o=0; start_i=1 -> WRITE next cycle, write counter cleared to 0.
REQ-018 WRITE: pix_ready_o=1 (combinational from state); accept occurs when pix_valid_i & pix_ready_o.
REQ-019 On accept with counter=k: register ena_o=1, wea_o=1, addra_o=k, d2mema_o=pix_data_i, driven on the following cycle (latency 1); counter -> k+1.
REQ-020 Cycles without accept SHALL drive ena_o=wea_o=0; addra_o and d2mema_o hold their last values.
REQ-021 Accept with counter=N-1 SHALL wrap the counter to 0 and move to DONE; no pixel is accepted in the cycle after the last accept.
REQ-022 DONE lasts exactly one cycle with frame_done_o=1; this cycle coincides with the write strobe of pixel N-1.
REQ-023 start_i SHALL be ignored in WRITE and DONE; pix_valid_i SHALL be ignored in IDLE and DONE (no write, no counter change).
REQ-024 start_i and pix_valid_i high together in IDLE: only the start takes effect; the pixel is first acceptable in the next cycle.
REQ-025 Counter SHALL be 19 bits unsigned and never exceed N-1.

Reset
REQ-026 rst=1 SHALL force state IDLE and counter 0, and set ena_o, wea_o, frame_done_o, busy_o, pix_ready_o, addra_o and d2mema_o to 0 on the next edge, including mid-frame.
REQ-027 A write registered before the reset edge SHALL NOT be emitted after reset; a partial frame is abandoned and the next start_i restarts at address 0.

Configuration
REQ-028 Macro FRAME_LOOP_EN SHALL select frame continuation.
REQ-029 With FRAME_LOOP_EN defined: DONE -> WRITE with counter 0, so frames are written back-to-back without start_i; busy_o stays 1 until reset.
REQ-030 Without FRAME_LOOP_EN: DONE -> IDLE; each frame requires its own start_i.

Verification (MAX_ROW=2, MAX_COL=3, N=6, unless noted)
REQ-031 Reset, then pix_valid_i=1 with no start -> no ena_o/wea_o pulse, pix_ready_o=0, busy_o=0.
REQ-032 start_i, then six continuous pixels 0x10..0x15 -> addra_o 0..5 with d2mema_o 0x10..0x15, each one cycle after its accept; frame_done_o high exactly once, in the same cycle as the addr-5 write; then IDLE.
REQ-033 Valid toggled 1,0,1,0... across a frame -> exactly 6 writes, gapless addresses 0..5, data order preserved.
REQ-034 rst asserted after 3 accepts -> all outputs 0 next cycle; after a new start_i, first write goes to address 0.
REQ-035 Start issued again during WRITE -> ignored, counter unaffected; start_i and valid together in IDLE -> first write carries the next-cycle pixel.
REQ-036 FRAME_LOOP_EN defined, 12 pixels after one start -> addresses 0..5,0..5, two frame_done_o pulses, busy_o stays 1.

Source files
------------

// File: rtl/mem_wr_a.sv
// mem_wr_a: streams one frame of 8-bit pixels into BRAM port A at sequential addresses 0..N-1.
// Define FRAME_LOOP_EN to start the next frame automatically after DONE instead of waiting in IDLE.
module mem_wr_a #(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_data_i,
  output logic        pix_ready_o,
  output logic        ena_o,
  output logic        wea_o,
  output logic [18:0] addra_o,
  output logic [7:0]  d2mema_o,
  input  logic [7:0]  mem2da_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int          N         = MAX_ROW * MAX_COL;
  localparam logic [18:0] LAST_ADDR = 19'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic        ena_q, ena_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        accept;

  // Read port is never used; the reduction keeps the input visibly consumed.
  logic unused_mem2da;
  assign unused_mem2da = ^mem2da_i;

  assign accept = pix_valid_i && (state_q == WRITE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ena_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (accept) begin
          ena_d  = 1'b1;
          addr_d = cnt_q;
          data_d = pix_data_i;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 19'd1;
          end
        end
      end
      DONE: begin
        cnt_d = '0;
`ifdef FRAME_LOOP_EN
        state_d = WRITE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // DONE follows the last accept directly, so it lines up with the strobe of pixel N-1.
  assign pix_ready_o  = (state_q == WRITE);
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == DONE);
  assign ena_o        = ena_q;
  assign wea_o        = ena_q;
  assign addra_o      = addr_q;
  assign d2mema_o     = data_q;

endmodule

// File: tb/tb_mem_wr_a.sv
// tb_mem_wr_a: scoreboard bench for mem_wr_a with a 2x3 frame (N=6).
// Expected writes are pushed by a protocol model when stimulus is applied and popped by the output monitor.
module tb_mem_wr_a;

  localparam int N = 6;

  typedef enum int {M_IDLE, M_WRITE, M_DONE} mstate_e;
  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        pix_valid_i;
  logic [7:0]  pix_data_i;
  logic        pix_ready_o;
  logic        ena_o;
  logic        wea_o;
  logic [18:0] addra_o;
  logic [7:0]  d2mema_o;
  logic [7:0]  mem2da_i;
  logic        busy_o;
  logic        frame_done_o;

  int          checkCount = 0;
  int          failCount  = 0;
  int          writeCount = 0;
  int          doneCount  = 0;
  exp_t        expQ[$];
  mstate_e     mState     = M_IDLE;
  int          mCnt       = 0;
  logic        monEn      = 1'b0;
  logic        justReset  = 1'b0;
  logic [18:0] lastAddr   = '0;
  logic [7:0]  lastData   = '0;

  mem_wr_a #(.MAX_ROW(2), .MAX_COL(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
    .pix_ready_o  (pix_ready_o),
    .ena_o        (ena_o),
    .wea_o        (wea_o),
    .addra_o      (addra_o),
    .d2mema_o     (d2mema_o),
    .mem2da_i     (mem2da_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: state outputs checked mid-cycle, model advanced on the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [7:0] d);
    exp_t e;
    rst         = r;
    start_i     = s;
    pix_valid_i = v;
    pix_data_i  = d;
    mem2da_i    = 8'($urandom_range(0, 255));
    @(negedge clk);
    if (monEn) begin
      checkOutput("pix_ready", {31'd0, pix_ready_o}, {31'd0, mState == M_WRITE});
      checkOutput("busy", {31'd0, busy_o}, {31'd0, mState != M_IDLE});
      if (justReset) begin
        checkOutput("rst ena", {31'd0, ena_o}, 32'd0);
        checkOutput("rst wea", {31'd0, wea_o}, 32'd0);
        checkOutput("rst addr", {13'd0, addra_o}, 32'd0);
        checkOutput("rst data", {24'd0, d2mema_o}, 32'd0);
        checkOutput("rst frame_done", {31'd0, frame_done_o}, 32'd0);
      end
    end
    @(posedge clk);
    justReset = 1'b0;
    if (r) begin
      mState    = M_IDLE;
      mCnt      = 0;
      expQ.delete();
      lastAddr  = '0;
      lastData  = '0;
      monEn     = 1'b1;
      justReset = 1'b1;
    end else begin
      case (mState)
        M_IDLE: if (s) begin mState = M_WRITE; mCnt = 0; end
        M_WRITE: if (v) begin
          e.addr = 19'(mCnt);
          e.data = d;
          e.last = (mCnt == N - 1);
          expQ.push_back(e);
          if (mCnt == N - 1) begin mCnt = 0; mState = M_DONE; end
          else mCnt++;
        end
        default: begin
          mCnt = 0;
`ifdef FRAME_LOOP_EN
          mState = M_WRITE;
`else
          mState = M_IDLE;
`endif
        end
      endcase
    end
    #1;
  endtask

  // Output monitor: every strobe must match the head of the queue; quiet cycles must hold addr/data.
  always @(negedge clk) begin
    exp_t e;
    if (monEn) begin
      if (ena_o === 1'b1) begin
        writeCount++;
        if (frame_done_o === 1'b1) doneCount++;
        checkOutput("write expected", {31'd0, expQ.size() != 0}, 32'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("addr", {13'd0, addra_o}, {13'd0, e.addr});
          checkOutput("data", {24'd0, d2mema_o}, {24'd0, e.data});
          checkOutput("wea", {31'd0, wea_o}, 32'd1);
          checkOutput("frame_done on write", {31'd0, frame_done_o}, {31'd0, e.last});
          lastAddr = e.addr;
          lastData = e.data;
        end
      end else begin
        checkOutput("idle ena", {31'd0, ena_o}, 32'd0);
        checkOutput("idle wea", {31'd0, wea_o}, 32'd0);
        checkOutput("idle frame_done", {31'd0, frame_done_o}, 32'd0);
        checkOutput("hold addr", {13'd0, addra_o}, {13'd0, lastAddr});
        checkOutput("hold data", {24'd0, d2mema_o}, {24'd0, lastData});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int d0;
    rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = '0; mem2da_i = '0;

    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'hE0 + 8'(i));
    checkOutput("no write without start", 32'(writeCount), 32'd0);

    // Continuous frame.
    w0 = writeCount; d0 = doneCount;
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00);
    checkOutput("frame writes", 32'(writeCount - w0), 32'd6);
    checkOutput("frame done pulses", 32'(doneCount - d0), 32'd1);

    // Toggled valid.
    w0 = writeCount; d0 = doneCount;
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 2 * N; i++) applyStimulus(0, 0, (i % 2) == 0, 8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00);
    checkOutput("toggle writes", 32'(writeCount - w0), 32'd6);
    checkOutput("toggle done pulses", 32'(doneCount - d0), 32'd1);

    // Reset mid-frame, then restart from address 0.
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h30 + 8'(i));
    applyStimulus(1, 0, 1, 8'h3F);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, 8'h40 + 8'(i));
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 8'h00);

    // Start during WRITE is ignored; start with valid in IDLE only starts.
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h60);
    applyStimulus(0, 1, 1, 8'h61);
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 2; i < N; i++) applyStimulus(0, 0, 1, 8'h60 + 8'(i));
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'hAA);
    applyStimulus(0, 0, 1, 8'hBB);
    for (int i = 1; i < N; i++) applyStimulus(0, 0, 1, 8'hC0 + 8'(i));
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 8'h00);

`ifdef FRAME_LOOP_EN
    applyStimulus(1, 0, 0, 8'h00);
    w0 = writeCount; d0 = doneCount;
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 2 * N + 1; i++) applyStimulus(0, 0, 1, 8'h70 + 8'(i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00);
    checkOutput("loop writes", 32'(writeCount - w0), 32'd12);
    checkOutput("loop done pulses", 32'(doneCount - d0), 32'd2);
    checkOutput("loop busy", {31'd0, busy_o}, 32'd1);
`endif

    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
